// File: rtl/fp_unit_driver.sv
// Credit-based driver for a fixed-latency FP unit with an in-order result FIFO.
// Optional protocol checker enabled by defining FP_UNIT_DRIVER_CHECK_EN.
module fp_unit_driver #(
  parameter int LATENCY = 11,
  parameter int DEPTH   = 16
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic        fu_go,
  output logic [31:0] fu_a,
  output logic [31:0] fu_b,
  input  logic        fu_done,
  input  logic [31:0] fu_result,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic        err
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

  if (DEPTH < 2 || DEPTH > 64 || LATENCY < 1) begin : gBadParams
    $error("fp_unit_driver: DEPTH must be 2..64 and LATENCY at least 1");
  end

  logic          armed;
  logic [CW-1:0] reserved;
  logic [CW-1:0] inflight;
  logic [CW-1:0] count;
  logic [PW-1:0] wrPtr;
  logic [PW-1:0] rdPtr;
  logic [31:0]   mem [DEPTH];
  logic          reqHs;
  logic          respHs;
  logic          doneAcc;

  // armed keeps req_ready low during reset and raises it on the first edge after release
  assign req_ready  = armed && (reserved < DEPTH_C);
  assign resp_valid = (count != '0);
  assign resp_data  = resp_valid ? mem[rdPtr] : '0;

  assign reqHs   = req_valid && req_ready;
  assign respHs  = resp_valid && resp_ready;
  assign doneAcc = fu_done && (inflight != '0);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      armed    <= 1'b0;
      reserved <= '0;
      inflight <= '0;
      count    <= '0;
      wrPtr    <= '0;
      rdPtr    <= '0;
      fu_go    <= 1'b0;
      fu_a     <= '0;
      fu_b     <= '0;
    end else begin
      armed    <= 1'b1;
      reserved <= reserved + CW'(reqHs) - CW'(respHs);
      inflight <= inflight + CW'(fu_go) - CW'(doneAcc);
      count    <= count + CW'(doneAcc) - CW'(respHs);
      fu_go    <= reqHs;
      if (reqHs) begin
        fu_a <= req_a;
        fu_b <= req_b;
      end
      if (doneAcc) begin
        wrPtr <= (wrPtr == LAST_PTR) ? '0 : wrPtr + PW'(1);
      end
      if (respHs) begin
        rdPtr <= (rdPtr == LAST_PTR) ? '0 : rdPtr + PW'(1);
      end
    end
  end

  // Storage needs no reset: entries only become visible through count
  always_ff @(posedge clock) begin
    if (doneAcc) begin
      mem[wrPtr] <= fu_result;
    end
  end

`ifdef FP_UNIT_DRIVER_CHECK_EN
  logic [LATENCY-1:0] goShadow;
  logic               errReg;

  // The oldest shadow bit marks the cycle in which a legal done must arrive
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      goShadow <= '0;
      errReg   <= 1'b0;
    end else begin
      goShadow[0] <= fu_go;
      for (int i = 1; i < LATENCY; i++) begin
        goShadow[i] <= goShadow[i-1];
      end
      if (fu_done && ((inflight == '0) || !goShadow[LATENCY-1])) begin
        errReg <= 1'b1;
      end
    end
  end

  assign err = errReg;
`else
  assign err = 1'b0;
`endif

endmodule
